// File: rtl/xs3_pkg.sv
// Shared constants and types for the serial excess-3 BCD add/subtract unit.
//   XS3_BIAS    : excess-3 offset applied to each BCD digit
//   BCD_MAX     : largest legal BCD digit value
//   alu_state_t : sequencer states
package xs3_pkg;

  localparam logic [3:0] XS3_BIAS = 4'd3;
  localparam logic [3:0] BCD_MAX  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/xs3_digit_cell.sv
// Combinational single-digit excess-3 add/subtract cell.
//   x, y  : BCD digits (x is the minuend for subtract)
//   sub   : 1 = x - y via nines complement of y in XS3
//   cin   : carry in (for subtract, carry 1 means "no borrow")
//   d_bcd : BCD result digit
//   cout  : decimal carry out
module xs3_digit_cell
  import xs3_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       sub,
  input  logic       cin,
  output logic [3:0] d_bcd,
  output logic       cout
);

  logic [3:0] xa;
  logic [3:0] yb;
  logic [4:0] s;
  logic [3:0] d;

  always_comb begin
    xa = x + XS3_BIAS;
    yb = y + XS3_BIAS;
    // Inverting an XS3 digit yields the XS3 code of its nines complement.
    if (sub) yb = ~yb;
    s  = {1'b0, xa} + {1'b0, yb} + {4'd0, cin};
    // Binary carry out of the 4-bit sum coincides with a decimal carry in XS3;
    // the bias is re-applied or removed accordingly to stay in XS3.
    if (s[4]) d = s[3:0] + XS3_BIAS;
    else      d = s[3:0] - XS3_BIAS;
    cout  = s[4];
    d_bcd = d - XS3_BIAS;
  end

endmodule

// File: rtl/bcd_serial_xs3_alu.sv
// Multi-digit BCD add / magnitude-subtract sequencer. One digit is processed
// per clock, least significant first, through a single time-shared XS3 cell.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (A, B, M sampled on accept)
//   A, B                 : packed BCD operands, digit 0 in bits [3:0]
//   M                    : 0 = A+B, 1 = |A-B|
//   out_valid / out_ready: result handshake, result held until taken
//   Result               : BCD sum or magnitude of difference
//   CarryOut             : add overflow past the top digit (0 for subtract)
//   Neg                  : subtract with A<B (0 for add)
//   Err                  : an operand nibble exceeded 9; Result is then 0
module bcd_serial_xs3_alu
  import xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  M,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   Result,
  output logic                  CarryOut,
  output logic                  Neg,
  output logic                  Err
);

  localparam int CNT_W = $clog2(DIGITS + 1);

  alu_state_t state, state_nxt;

  logic [4*DIGITS-1:0] x_q, y_q, res_q, res_nxt;
  logic [CNT_W-1:0]    cnt_q;
  logic                cin_q, m_q, carry_q, neg_q, err_q;

  logic       accept, last, bad, a_lt_b;
  logic [3:0] d_bcd;
  logic       cout;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt_q == CNT_W'(DIGITS - 1));
  assign a_lt_b    = (A < B);

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (A[4*i +: 4] > BCD_MAX || B[4*i +: 4] > BCD_MAX) bad = 1'b1;
  end

  // Operands shift right one digit per RUN cycle, so the cell always sees
  // the current digit in the low nibble.
  xs3_digit_cell u_cell (
    .x     (x_q[3:0]),
    .y     (y_q[3:0]),
    .sub   (m_q),
    .cin   (cin_q),
    .d_bcd (d_bcd),
    .cout  (cout)
  );

  // Result fills from the top; after DIGITS shifts digit 0 sits at [3:0].
  generate
    if (DIGITS == 1) begin : g_res_one
      assign res_nxt = d_bcd;
    end else begin : g_res_shift
      assign res_nxt = {d_bcd, res_q[4*DIGITS-1:4]};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad ? DONE : RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          // Subtract always runs larger-minus-smaller; the sign is kept aside.
          if (M && a_lt_b) begin
            x_q <= B;
            y_q <= A;
          end else begin
            x_q <= A;
            y_q <= B;
          end
          neg_q   <= M && a_lt_b;
          err_q   <= bad;
          m_q     <= M;
          cin_q   <= M;
          cnt_q   <= '0;
          res_q   <= '0;
          carry_q <= 1'b0;
        end
        RUN: begin
          x_q   <= x_q >> 4;
          y_q   <= y_q >> 4;
          res_q <= res_nxt;
          cin_q <= cout;
          cnt_q <= cnt_q + CNT_W'(1);
          // Subtract's final carry is only the end-around "no borrow" marker.
          if (last) carry_q <= cout && !m_q;
        end
        default: ;
      endcase
    end
  end

  assign Result   = res_q;
  assign CarryOut = carry_q;
  assign Neg      = neg_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_bcd_serial_xs3_alu.sv
module tb_bcd_serial_xs3_alu;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [4*D-1:0] A, B;
  logic          M;
  logic          out_valid;
  logic          out_ready;
  logic [4*D-1:0] Result;
  logic          CarryOut, Neg, Err;

  int errors = 0;
  int checks = 0;

  bcd_serial_xs3_alu #(.DIGITS(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .M(M), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .CarryOut(CarryOut), .Neg(Neg), .Err(Err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [4*D-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [4*D-1:0] int2bcd(input int n);
    logic [4*D-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [4*D-1:0] a, input logic [4*D-1:0] b);
    for (int i = 0; i < D; i++)
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4*D-1:0] rand_bcd();
    logic [4*D-1:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Presents one beat and waits (bounded) for out_valid. lat counts clock
  // edges after the accept edge before out_valid is seen.
  task automatic launch(input logic [4*D-1:0] a, input logic [4*D-1:0] b,
                        input logic m, output int lat);
    @(negedge clk);
    check("ready_before_beat", in_ready, 1);
    A = a; B = b; M = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full operation checked against integer arithmetic.
  task automatic run_op(input string tag, input logic [4*D-1:0] a,
                        input logic [4*D-1:0] b, input logic m);
    int lat, ai, bi, r;
    logic err_e, carry_e, neg_e;
    logic [4*D-1:0] res_e;
    err_e = has_bad(a, b);
    ai = bcd2int(a);
    bi = bcd2int(b);
    carry_e = 1'b0;
    neg_e = 1'b0;
    if (err_e) res_e = '0;
    else if (!m) begin
      r = ai + bi;
      carry_e = (r >= 10000);
      res_e = int2bcd(r % 10000);
    end else begin
      neg_e = (ai < bi);
      res_e = int2bcd(neg_e ? bi - ai : ai - bi);
    end
    launch(a, b, m, lat);
    check({tag, "_lat"}, lat, err_e ? 0 : D);
    check({tag, "_res"}, Result, res_e);
    check({tag, "_err"}, Err, err_e);
    check({tag, "_rdy_low"}, in_ready, 0);
    if (!err_e) begin
      check({tag, "_carry"}, CarryOut, carry_e);
      check({tag, "_neg"}, Neg, neg_e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    logic [4*D-1:0] held;
    logic [4*D-1:0] bad_a;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; M = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_result", Result, 0);
    check("rst_flags", {CarryOut, Neg, Err}, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add_0999", 16'h0999, 16'h0001, 1'b0);
    run_op("add_9999", 16'h9999, 16'h0001, 1'b0);
    run_op("sub_neg",  16'h0042, 16'h0100, 1'b1);
    run_op("sub_eq",   16'h1234, 16'h1234, 1'b1);
    run_op("err_a5",   16'h00A5, 16'h0001, 1'b0);
    run_op("sub_pos",  16'h5000, 16'h0001, 1'b1);

    for (int i = 0; i < 16; i++)
      run_op($sformatf("rnd%0d", i), rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)));

    bad_a = rand_bcd();
    bad_a[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
    run_op("rnd_err", bad_a, rand_bcd(), 1'b0);

    // Backpressure: DONE holds, busy in_valid is ignored.
    out_ready = 1'b0;
    launch(16'h0456, 16'h0123, 1'b0, lat);
    check("bp_lat", lat, D);
    held = Result;
    check("bp_res", held, 16'h0579);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      A = 16'h9999; B = 16'h9999; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1);
      check("bp_ready", in_ready, 0);
      check("bp_hold", Result, 16'h0579);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_valid", out_valid, 0);
    check("bp_rel_ready", in_ready, 1);

    // Reset in the middle of RUN.
    @(negedge clk);
    A = 16'h4321; B = 16'h1111; M = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", in_ready, 0);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_res", Result, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op("after_rst", 16'h4321, 16'h1111, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
